// File: rtl/snake_pkg.sv
// Shared definitions for the snake game: direction codes, engine FSM states and
// default playfield geometry used by the engine, food generator and renderer.
package snake_pkg;

  localparam int COORD_W = 10;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  localparam int DEF_SCREEN_WIDTH  = 640;
  localparam int DEF_SCREEN_HEIGHT = 480;
  localparam int DEF_SEGMENT_SIZE  = 10;

  typedef enum logic [2:0] {
    ST_PLAY   = 3'd0,
    ST_MOVE   = 3'd1,
    ST_SCAN   = 3'd2,
    ST_UPDATE = 3'd3,
    ST_OVER   = 3'd4
  } state_e;

  // Up/down and left/right share bit 1 and differ in bit 0.
  function automatic logic dir_opposite(input logic [1:0] a, input logic [1:0] b);
    return (a[1] == b[1]) && (a[0] != b[0]);
  endfunction

endpackage

// File: rtl/snake_engine_tick_gen.sv
// Movement-rate divider: counts 0..TICK_DIV-1 and raises tick_o for the single
// cycle in which the counter wraps.
module tick_gen #(
  parameter int TICK_DIV = 5000000
) (
  input  logic clk_i,
  input  logic reset_i,
  output logic tick_o
);

  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q;

  // Free-running divider counter
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign tick_o = (cnt_q == CNT_LAST);

endmodule

// File: rtl/snake_engine.sv
// Snake game core: holds the body, advances it once per tick, detects wall and
// self collisions, grows on food and answers renderer occupancy queries.
module snake_engine
  import snake_pkg::*;
#(
  parameter int SCREEN_WIDTH  = DEF_SCREEN_WIDTH,
  parameter int SCREEN_HEIGHT = DEF_SCREEN_HEIGHT,
  parameter int SEGMENT_SIZE  = DEF_SEGMENT_SIZE,
  parameter int MAX_LEN       = 32,
  parameter int INIT_LEN      = 3,
  parameter int TICK_DIV      = 5000000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         dir_in,
  input  logic               dir_valid,
  input  logic [COORD_W-1:0] food_x,
  input  logic [COORD_W-1:0] food_y,
  input  logic [COORD_W-1:0] query_x,
  input  logic [COORD_W-1:0] query_y,
  output logic               food_eaten,
  output logic [COORD_W-1:0] head_x,
  output logic [COORD_W-1:0] head_y,
  output logic [5:0]         length,
  output logic               game_over,
  output logic               query_hit
);

  localparam int IW = (MAX_LEN > 2) ? $clog2(MAX_LEN) : 1;
  localparam logic [COORD_W-1:0] SEG   = COORD_W'(SEGMENT_SIZE);
  localparam logic [COORD_W-1:0] X_MAX = COORD_W'(SCREEN_WIDTH - SEGMENT_SIZE);
  localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(SCREEN_HEIGHT - SEGMENT_SIZE);
  localparam logic [5:0] LEN_MAX  = 6'(MAX_LEN);
  localparam logic [5:0] LEN_INIT = 6'(INIT_LEN);

  state_e state_q, state_d;
  logic [COORD_W-1:0] seg_x_q [MAX_LEN];
  logic [COORD_W-1:0] seg_y_q [MAX_LEN];
  logic [1:0]  dir_q, pending_q;
  logic [5:0]  len_q, scan_limit_q, idx_q;
  logic [COORD_W-1:0] next_x_q, next_y_q, next_x_s, next_y_s;
  logic grow_q, query_hit_q;
  logic tick_s, wall_s, grow_s, seg_hit_s, scan_done_s, query_match_s;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk_i   (clk),
    .reset_i (reset),
    .tick_o  (tick_s)
  );

  // Candidate head position; wall is tested before any subtraction is used
  always_comb begin
    next_x_s = seg_x_q[0];
    next_y_s = seg_y_q[0];
    wall_s   = 1'b0;
    case (pending_q)
      DIR_UP:    begin wall_s = (seg_y_q[0] == '0);    next_y_s = seg_y_q[0] - SEG; end
      DIR_DOWN:  begin wall_s = (seg_y_q[0] == Y_MAX); next_y_s = seg_y_q[0] + SEG; end
      DIR_LEFT:  begin wall_s = (seg_x_q[0] == '0);    next_x_s = seg_x_q[0] - SEG; end
      default:   begin wall_s = (seg_x_q[0] == X_MAX); next_x_s = seg_x_q[0] + SEG; end
    endcase
  end

  assign grow_s      = (next_x_s == food_x) && (next_y_s == food_y);
  assign seg_hit_s   = (seg_x_q[idx_q[IW-1:0]] == next_x_q) && (seg_y_q[idx_q[IW-1:0]] == next_y_q);
  assign scan_done_s = ((idx_q + 6'd1) == scan_limit_q);

  // Renderer occupancy lookup over live segments only
  always_comb begin
    query_match_s = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if ((6'(i) < len_q) && (seg_x_q[i] == query_x) && (seg_y_q[i] == query_y)) begin
        query_match_s = 1'b1;
      end else begin
        query_match_s = query_match_s;
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_PLAY;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_PLAY:   if (tick_s) state_d = ST_MOVE; else state_d = ST_PLAY;
      ST_MOVE:   if (wall_s) state_d = ST_OVER; else state_d = ST_SCAN;
      ST_SCAN: begin
        if (seg_hit_s)        state_d = ST_OVER;
        else if (scan_done_s) state_d = ST_UPDATE;
        else                  state_d = ST_SCAN;
      end
      ST_UPDATE: state_d = ST_PLAY;
      ST_OVER:   state_d = ST_OVER;
      default:   state_d = ST_PLAY;
    endcase
  end

  // FSM outputs decoded from registered state
  always_comb begin
    food_eaten = 1'b0;
    game_over  = 1'b0;
    case (state_q)
      ST_UPDATE: food_eaten = grow_q;
      ST_OVER:   game_over  = 1'b1;
      default:   food_eaten = 1'b0;
    endcase
  end

  // Body storage, direction latch, scan bookkeeping and query register
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        if (i < INIT_LEN) begin
          seg_x_q[i] <= COORD_W'(SCREEN_WIDTH / 2 - i * SEGMENT_SIZE);
          seg_y_q[i] <= COORD_W'(SCREEN_HEIGHT / 2);
        end else begin
          seg_x_q[i] <= '0;
          seg_y_q[i] <= '0;
        end
      end
      dir_q        <= DIR_RIGHT;
      pending_q    <= DIR_RIGHT;
      len_q        <= LEN_INIT;
      next_x_q     <= '0;
      next_y_q     <= '0;
      grow_q       <= 1'b0;
      scan_limit_q <= 6'd0;
      idx_q        <= 6'd0;
      query_hit_q  <= 1'b0;
    end else begin
      if ((state_q != ST_OVER) && dir_valid && !dir_opposite(dir_in, dir_q)) begin
        pending_q <= dir_in;
      end
      case (state_q)
        ST_MOVE: begin
          dir_q        <= pending_q;
          next_x_q     <= next_x_s;
          next_y_q     <= next_y_s;
          grow_q       <= grow_s;
          scan_limit_q <= grow_s ? len_q : (len_q - 6'd1);
          idx_q        <= 6'd0;
        end
        ST_SCAN: idx_q <= idx_q + 6'd1;
        ST_UPDATE: begin
          for (int i = 1; i < MAX_LEN; i++) begin
            seg_x_q[i] <= seg_x_q[i-1];
            seg_y_q[i] <= seg_y_q[i-1];
          end
          seg_x_q[0] <= next_x_q;
          seg_y_q[0] <= next_y_q;
          if (grow_q && (len_q != LEN_MAX)) begin
            len_q <= len_q + 6'd1;
          end
        end
        default: idx_q <= idx_q;
      endcase
      query_hit_q <= query_match_s;
    end
  end

  assign head_x    = seg_x_q[0];
  assign head_y    = seg_y_q[0];
  assign length    = len_q;
  assign query_hit = query_hit_q;

endmodule

// File: tb/tb_snake_engine.sv
// Self-checking bench for snake_engine: directed scenarios plus randomized play
// compared against a queue-based model of the game rules.
module tb_snake_engine;

  localparam int TD = 40;
  localparam int ML = 8;
  localparam int STEP_BUDGET = TD + ML + 20;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] dir_in = 2'd0;
  logic       dir_valid = 1'b0;
  logic [9:0] food_x = 10'd0, food_y = 10'd0;
  logic [9:0] query_x = 10'd0, query_y = 10'd0;
  logic       food_eaten, game_over, query_hit;
  logic [9:0] head_x, head_y;
  logic [5:0] length;

  int checks = 0;
  int errors = 0;

  // Behavioural model: body as a queue with the head at index 0
  int mx[$];
  int my[$];
  int m_dir, m_pend, m_fx, m_fy;
  bit m_over;

  snake_engine #(
    .SCREEN_WIDTH(640), .SCREEN_HEIGHT(480), .SEGMENT_SIZE(10),
    .MAX_LEN(ML), .INIT_LEN(3), .TICK_DIV(TD)
  ) dut (
    .clk(clk), .reset(reset), .dir_in(dir_in), .dir_valid(dir_valid),
    .food_x(food_x), .food_y(food_y), .query_x(query_x), .query_y(query_y),
    .food_eaten(food_eaten), .head_x(head_x), .head_y(head_y),
    .length(length), .game_over(game_over), .query_hit(query_hit)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic bit opposite(input int a, input int b);
    return (a == 0 && b == 1) || (a == 1 && b == 0) || (a == 2 && b == 3) || (a == 3 && b == 2);
  endfunction

  function automatic bit occupied(input int x, input int y);
    for (int i = 0; i < mx.size(); i++)
      if (mx[i] == x && my[i] == y) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    mx.delete(); my.delete();
    for (int i = 0; i < 3; i++) begin
      mx.push_back(320 - 10 * i);
      my.push_back(240);
    end
    m_dir = 3; m_pend = 3; m_over = 1'b0;
  endtask

  task automatic model_step(output bit exp_fe);
    int nx, ny, lim;
    bit wall, grow;
    exp_fe = 1'b0;
    if (m_over) return;
    m_dir = m_pend;
    nx = mx[0]; ny = my[0]; wall = 1'b0;
    case (m_dir)
      0: if (ny == 0)   wall = 1'b1; else ny = ny - 10;
      1: if (ny == 470) wall = 1'b1; else ny = ny + 10;
      2: if (nx == 0)   wall = 1'b1; else nx = nx - 10;
      default: if (nx == 630) wall = 1'b1; else nx = nx + 10;
    endcase
    if (wall) begin m_over = 1'b1; return; end
    grow = (nx == m_fx) && (ny == m_fy);
    lim = grow ? mx.size() : mx.size() - 1;
    for (int i = 0; i < lim; i++)
      if (mx[i] == nx && my[i] == ny) begin m_over = 1'b1; return; end
    mx.push_front(nx); my.push_front(ny);
    if (!grow || mx.size() > ML) begin
      void'(mx.pop_back()); void'(my.pop_back());
    end
    exp_fe = grow;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; dir_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic set_food(input int x, input int y);
    food_x = 10'(x); food_y = 10'(y);
    m_fx = x; m_fy = y;
  endtask

  task automatic req_dir(input int d);
    @(negedge clk);
    dir_in = 2'(d); dir_valid = 1'b1;
    if (!m_over && !opposite(d, m_dir)) m_pend = d;
    @(negedge clk);
    dir_valid = 1'b0;
  endtask

  // One movement period: waits for the DUT to finish the step and compares
  task automatic do_step(input string tag);
    bit exp_fe, was_over, done;
    int old_len, fe_cnt;
    logic [9:0] hx0, hy0;
    was_over = m_over;
    old_len = mx.size();
    hx0 = head_x; hy0 = head_y;
    model_step(exp_fe);
    fe_cnt = 0; done = 1'b0;
    for (int c = 0; c < STEP_BUDGET && !done; c++) begin
      @(negedge clk);
      if (food_eaten === 1'b1) begin
        fe_cnt++;
        checks++;
        if (length !== 6'(old_len)) begin
          errors++;
          $display("FAIL %s len_during_pulse: got %0d want %0d", tag, length, old_len);
        end
      end
      if (!was_over && (head_x !== hx0 || head_y !== hy0 || game_over === 1'b1)) done = 1'b1;
    end
    if (!was_over) begin
      checks++;
      if (!done) begin errors++; $display("FAIL %s step_timeout: no move within %0d cycles", tag, STEP_BUDGET); end
    end
    checks++;
    if (head_x !== 10'(mx[0]) || head_y !== 10'(my[0])) begin
      errors++; $display("FAIL %s head: got (%0d,%0d) want (%0d,%0d)", tag, head_x, head_y, mx[0], my[0]);
    end
    checks++;
    if (length !== 6'(mx.size())) begin errors++; $display("FAIL %s length: got %0d want %0d", tag, length, mx.size()); end
    checks++;
    if (game_over !== m_over) begin errors++; $display("FAIL %s game_over: got %0b want %0b", tag, game_over, m_over); end
    checks++;
    if (fe_cnt != int'(exp_fe)) begin errors++; $display("FAIL %s food_eaten_cycles: got %0d want %0d", tag, fe_cnt, exp_fe); end
  endtask

  task automatic check_q(input int x, input int y, input string tag);
    bit exp;
    @(negedge clk);
    query_x = 10'(x); query_y = 10'(y);
    exp = occupied(x, y);
    @(negedge clk);
    checks++;
    if (query_hit !== exp) begin errors++; $display("FAIL %s query(%0d,%0d): got %0b want %0b", tag, x, y, query_hit, exp); end
  endtask

  task automatic test_reset();
    set_food(0, 0);
    query_x = 10'd0; query_y = 10'd0;
    do_reset();
    checks++;
    if (head_x !== 10'd320 || head_y !== 10'd240) begin errors++; $display("FAIL reset_head: got (%0d,%0d) want (320,240)", head_x, head_y); end
    checks++;
    if (length !== 6'd3) begin errors++; $display("FAIL reset_length: got %0d want 3", length); end
    checks++;
    if (game_over !== 1'b0 || food_eaten !== 1'b0 || query_hit !== 1'b0) begin
      errors++; $display("FAIL reset_flags: got go=%0b fe=%0b qh=%0b want 0 0 0", game_over, food_eaten, query_hit);
    end
    check_q(310, 240, "reset_seg1");
    check_q(290, 240, "reset_beyond_len");
    check_q(300, 240, "reset_tail");
  endtask

  task automatic test_straight_grow_dir();
    do_step("straight1");
    do_step("straight2");
    checks++;
    if (head_x !== 10'd340) begin errors++; $display("FAIL straight_head_x: got %0d want 340", head_x); end
    check_q(320, 240, "straight_tail");
    check_q(310, 240, "straight_vacated");
    set_food(350, 240);
    do_step("grow");
    set_food(0, 470);
    check_q(320, 240, "grow_tail_kept");
    req_dir(2);
    do_step("opposite_ignored");
    req_dir(0);
    do_step("turn_up");
    checks++;
    if (head_x !== 10'd360 || head_y !== 10'd230) begin errors++; $display("FAIL turn_up_head: got (%0d,%0d) want (360,230)", head_x, head_y); end
  endtask

  task automatic test_wall();
    do_reset();
    set_food(0, 0);
    for (int s = 0; s < 31; s++) do_step("wall_run");
    do_step("wall_hit");
    checks++;
    if (game_over !== 1'b1 || head_x !== 10'd630) begin errors++; $display("FAIL wall_over: got go=%0b hx=%0d want 1 630", game_over, head_x); end
    set_food(630, 240);
    req_dir(1);
    do_step("over_frozen1");
    do_step("over_frozen2");
  endtask

  task automatic test_self(input int grow_to);
    do_reset();
    set_food(330, 240);
    do_step("self_grow1");
    if (grow_to == 5) begin
      set_food(340, 240);
      do_step("self_grow2");
    end
    set_food(0, 0);
    req_dir(1); do_step("self_down");
    req_dir(2); do_step("self_left");
    req_dir(0); do_step("self_up");
    checks++;
    if (game_over !== (grow_to == 5)) begin errors++; $display("FAIL self_len%0d: got go=%0b want %0b", grow_to, game_over, grow_to == 5); end
  endtask

  task automatic test_saturate();
    do_reset();
    for (int s = 0; s < 7; s++) begin
      set_food(mx[0] + 10, 240);
      do_step("saturate");
    end
    checks++;
    if (length !== 6'(ML)) begin errors++; $display("FAIL saturate_len: got %0d want %0d", length, ML); end
    check_q(mx[ML-1], 240, "saturate_tail");
    check_q(mx[ML-1] - 10, 240, "saturate_dropped");
  endtask

  task automatic test_reset_in_scan();
    do_reset();
    set_food(0, 0);
    do_step("pre_scan");
    query_x = head_x; query_y = head_y;
    repeat (TD - 3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    checks++;
    if (head_x !== 10'd320 || head_y !== 10'd240 || length !== 6'd3 || query_hit !== 1'b0 || game_over !== 1'b0) begin
      errors++; $display("FAIL reset_in_scan: got head(%0d,%0d) len %0d qh %0b go %0b want (320,240) 3 0 0",
                          head_x, head_y, length, query_hit, game_over);
    end
    model_reset();
    do_step("after_scan_reset");
  endtask

  task automatic test_random();
    int nreq, d, ax, ay, k;
    for (int r = 0; r < 3; r++) begin
      do_reset();
      for (int s = 0; s < 25; s++) begin
        nreq = $urandom_range(0, 3);
        for (int q = 0; q < nreq; q++) req_dir($urandom_range(0, 3));
        d = m_pend; ax = mx[0]; ay = my[0];
        case (d)
          0: ay = ay - 10;
          1: ay = ay + 10;
          2: ax = ax - 10;
          default: ax = ax + 10;
        endcase
        if ($urandom_range(0, 1) == 1 && ax >= 0 && ax <= 630 && ay >= 0 && ay <= 470)
          set_food(ax, ay);
        else
          set_food($urandom_range(0, 63) * 10, $urandom_range(0, 47) * 10);
        do_step("random");
        k = $urandom_range(0, mx.size() - 1);
        check_q(mx[k], my[k], "random_body");
        check_q(mx[0] + 10 * $urandom_range(0, 2), my[0] + 10 * $urandom_range(0, 1), "random_near");
      end
    end
  endtask

  initial begin
    test_reset();
    test_straight_grow_dir();
    test_wall();
    test_self(5);
    test_self(4);
    test_saturate();
    test_reset_in_scan();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
